press_count_decoder: RTL and testbench

Input-side decoder for the board's user buttons: it counts debounced presses of a single button and reports the total as a 4-bit value once the button has been idle long enough. A press held long enough is reported as a separate long-press event and produces no count. It sits after a debouncer, sharing the system clock. It uses the clock-divider tick as its time base, and its value/valid output feeds the LED and counter logic.

---
 rtl/press_count_decoder.sv | 171 +++++++++++++++++
 tb/tb_press_count_decoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/press_count_decoder.sv
// Button press-burst decoder: counts debounced presses in a burst and reports the
// total once the button has been idle for a gap; long holds become a separate event.
module press_count_decoder #(
  parameter int LONG_TICKS = 4,
  parameter int GAP_TICKS  = 3,
  parameter int TICK_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       press,
  output logic [3:0] value,
  output logic       valid,
  output logic       long_press,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    RELEASED = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [TICK_WIDTH-1:0] TCNT_ZERO = {TICK_WIDTH{1'b0}};
  localparam logic [TICK_WIDTH-1:0] TCNT_ONE  = TICK_WIDTH'(1);
  localparam logic [TICK_WIDTH-1:0] HOLD_LAST = TICK_WIDTH'(LONG_TICKS - 1);
  localparam logic [TICK_WIDTH-1:0] GAP_LAST  = TICK_WIDTH'(GAP_TICKS - 1);

  state_t                state_r, state_s;
  logic                  press_q_r;
  logic                  rise_s, fall_s;
  logic [3:0]            count_r, count_s;
  logic [TICK_WIDTH-1:0] hold_r, hold_s;
  logic [TICK_WIDTH-1:0] gap_r, gap_s;
  logic [3:0]            value_r, value_s;
  logic                  valid_r, valid_s;
  logic                  long_press_r, long_press_s;
  logic                  busy_r, busy_s;

  // Count never wraps: a burst longer than 15 presses reports 15.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    logic [3:0] r;
    if (c == 4'd15) begin
      r = 4'd15;
    end else begin
      r = c + 4'd1;
    end
    return r;
  endfunction

  assign rise_s = press & ~press_q_r;
  assign fall_s = ~press & press_q_r;

  // State, counters, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      press_q_r    <= 1'b0;
      count_r      <= 4'd0;
      hold_r       <= TCNT_ZERO;
      gap_r        <= TCNT_ZERO;
      value_r      <= 4'd0;
      valid_r      <= 1'b0;
      long_press_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      press_q_r    <= press;
      count_r      <= count_s;
      hold_r       <= hold_s;
      gap_r        <= gap_s;
      value_r      <= value_s;
      valid_r      <= valid_s;
      long_press_r <= long_press_s;
      busy_r       <= busy_s;
    end
  end

  // Next-state and next-output decode; edges take priority over ticks.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    hold_s       = hold_r;
    gap_s        = gap_r;
    value_s      = value_r;
    valid_s      = 1'b0;
    long_press_s = 1'b0;

    case (state_r)
      IDLE: begin
        count_s = 4'd0;
        hold_s  = TCNT_ZERO;
        gap_s   = TCNT_ZERO;
        if (rise_s) begin
          state_s = PRESSED;
          count_s = 4'd1;
        end else begin
          state_s = IDLE;
        end
      end

      PRESSED: begin
        if (fall_s) begin
          state_s = RELEASED;
          gap_s   = TCNT_ZERO;
          hold_s  = TCNT_ZERO;
        end else if (tick) begin
          if (hold_r == HOLD_LAST) begin
            state_s      = HOLD;
            long_press_s = 1'b1;
            count_s      = 4'd0;
            hold_s       = TCNT_ZERO;
            gap_s        = TCNT_ZERO;
          end else begin
            hold_s = hold_r + TCNT_ONE;
          end
        end else begin
          state_s = PRESSED;
        end
      end

      HOLD: begin
        if (fall_s) begin
          state_s = IDLE;
          hold_s  = TCNT_ZERO;
          gap_s   = TCNT_ZERO;
        end else begin
          state_s = HOLD;
        end
      end

      RELEASED: begin
        if (rise_s) begin
          state_s = PRESSED;
          hold_s  = TCNT_ZERO;
          gap_s   = TCNT_ZERO;
          count_s = sat_inc(count_r);
        end else if (tick) begin
          if (gap_r == GAP_LAST) begin
            state_s = IDLE;
            value_s = count_r;
            valid_s = 1'b1;
            count_s = 4'd0;
            hold_s  = TCNT_ZERO;
            gap_s   = TCNT_ZERO;
          end else begin
            gap_s = gap_r + TCNT_ONE;
          end
        end else begin
          state_s = RELEASED;
        end
      end

      default: begin
        state_s = IDLE;
        count_s = 4'd0;
        hold_s  = TCNT_ZERO;
        gap_s   = TCNT_ZERO;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  assign value      = value_r;
  assign valid      = valid_r;
  assign long_press = long_press_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_press_count_decoder.sv
// Directed bench for press_count_decoder: strobes are matched against a queue of
// expected {valid, long_press, value} events pushed when each scenario starts.
module tb_press_count_decoder;

  localparam int LONG_TICKS  = 4;
  localparam int GAP_TICKS   = 3;
  localparam int TICK_WIDTH  = 8;
  localparam int TICK_PERIOD = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       press;
  logic [3:0] value;
  logic       valid;
  logic       long_press;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [5:0] exp_q[$];

  press_count_decoder #(
    .LONG_TICKS(LONG_TICKS),
    .GAP_TICKS (GAP_TICKS),
    .TICK_WIDTH(TICK_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .press     (press),
    .value     (value),
    .valid     (valid),
    .long_press(long_press),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk cycle of stimulus; any strobe is matched against the scoreboard.
  task automatic step(input logic p);
    logic [5:0] e;
    press = p;
    tick  = ((cyc % TICK_PERIOD) == (TICK_PERIOD - 1));
    cyc++;
    @(posedge clk);
    #1;
    if (valid === 1'b1 || long_press === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {2'b00, valid, long_press, value}, 8'h00);
      end else begin
        e = exp_q.pop_front();
        chk("strobe", {2'b00, valid, long_press, value}, {2'b00, e});
      end
    end
  endtask

  task automatic steps(input logic p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  initial begin
    int t;
    rst   = 1'b1;
    press = 1'b0;
    tick  = 1'b0;

    // Reset
    steps(1'b0, 3);
    chk("reset_outputs", {1'b0, value, valid, long_press, busy}, 8'h00);
    rst = 1'b0;
    steps(1'b0, 50);
    chk("idle_after_reset", {1'b0, value, valid, long_press, busy}, 8'h00);

    // Three short presses, one tick each, one-tick gaps
    exp_q.push_back({1'b1, 1'b0, 4'd3});
    step(1'b1);
    chk("busy_rise", {7'd0, busy}, 8'd1);
    steps(1'b1, 9);
    steps(1'b0, 10);
    steps(1'b1, 10);
    steps(1'b0, 10);
    steps(1'b1, 10);
    steps(1'b0, 40);
    chk("three_drained", 8'(exp_q.size()), 8'd0);
    chk("three_busy_low", {3'd0, value, busy}, {3'd0, 4'd3, 1'b0});

    // Long press: held 5 ticks, event at the 4th, value keeps 3
    exp_q.push_back({1'b0, 1'b1, 4'd3});
    steps(1'b1, 50);
    chk("hold_busy", {7'd0, busy}, 8'd1);
    step(1'b0);
    chk("long_release_idle", {3'd0, value, busy}, {3'd0, 4'd3, 1'b0});
    steps(1'b0, 40);
    chk("long_drained", 8'(exp_q.size()), 8'd0);

    // Saturation: 20 quick presses report 15
    exp_q.push_back({1'b1, 1'b0, 4'd15});
    for (int i = 0; i < 20; i++) begin
      steps(1'b1, 3);
      steps(1'b0, 3);
    end
    steps(1'b0, 40);
    chk("sat_drained", 8'(exp_q.size()), 8'd0);

    // Rising edge on the terminal gap tick continues the burst
    exp_q.push_back({1'b1, 1'b0, 4'd2});
    steps(1'b1, 5);
    step(1'b0);
    t = 0;
    while (t < 2) begin
      if ((cyc % TICK_PERIOD) == (TICK_PERIOD - 1)) t++;
      step(1'b0);
    end
    while ((cyc % TICK_PERIOD) != (TICK_PERIOD - 1)) step(1'b0);
    step(1'b1);
    chk("simul_busy", {6'd0, valid, busy}, 8'd1);
    steps(1'b1, 5);
    steps(1'b0, 40);
    chk("simul_drained", 8'(exp_q.size()), 8'd0);

    // Reset mid-burst drops it silently
    steps(1'b1, 5);
    steps(1'b0, 5);
    steps(1'b1, 5);
    steps(1'b0, 5);
    chk("midburst_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    step(1'b0);
    chk("midburst_reset", {1'b0, value, valid, long_press, busy}, 8'h00);
    rst = 1'b0;
    steps(1'b0, 40);
    chk("midburst_quiet", {1'b0, value, valid, long_press, busy}, 8'h00);
    chk("final_drained", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
